alu_scheduler: RTL and testbench

Round-robin scheduler that shares one registered 4-op ALU (add, sub, not A, reduction-OR B; 1-cycle result latency) between NUM_REQ requesters. Accepts one request per operation via valid/ready and drives the ALU operand/opcode inputs. Captures the ALU result and returns it, tagged with the requester ID, through a valid/ready response port. Sits between the requesting units and the ALU instance; ALU reset is the same `reset`.

---
 rtl/alu_scheduler.sv | 178 +++++++++++++++++
 tb/tb_alu_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// Round-robin front end that shares one registered 4-op ALU between NUM_REQ requesters.
// Issues one operation at a time and returns the captured result tagged with the requester ID.
module alu_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [2*NUM_REQ-1:0]      req_opcode,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [1:0]                alu_opcode,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic                      alu_valid,
  input  logic [DATA_W:0]           alu_c,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [1:0]                rsp_opcode,
  output logic [DATA_W:0]           rsp_data,
  output logic                      busy,
  output logic [15:0]               ops_done
);

  localparam int unsigned RES_W = DATA_W + 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]         alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic               alu_valid_q, alu_valid_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [1:0]         rsp_opcode_q, rsp_opcode_d;
  logic [RES_W-1:0]   rsp_data_q, rsp_data_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   ops_done_q, ops_done_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [1:0]         sel_opcode;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;

  // (base + off) mod NUM_REQ for base, off < NUM_REQ
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // First valid requester at or after rr_ptr, ascending with wrap
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!grant_found && req_valid[i] && (rr_index(rr_ptr_q, k) == ID_W'(i))) begin
          grant_found = 1'b1;
          grant_idx   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    sel_opcode = '0;
    sel_a      = '0;
    sel_b      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_opcode = req_opcode[2*i +: 2];
        sel_a      = req_a[DATA_W*i +: DATA_W];
        sel_b      = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_data_d   = rsp_data_q;
    ops_done_d   = ops_done_q;
    req_ready    = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) req_ready[i] = 1'b1;
          end
          alu_opcode_d = sel_opcode;
          alu_a_d      = sel_a;
          alu_b_d      = sel_b;
          rsp_id_d     = grant_idx;
          rsp_opcode_d = sel_opcode;
          rr_ptr_d     = rr_index(grant_idx, 1);
          state_d      = EXEC;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        rsp_data_d = alu_c;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          ops_done_d = ops_done_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A cycle with reset asserted never completes a request handshake
    if (reset) req_ready = '0;

    alu_valid_d = (state_d == EXEC);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_valid_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_opcode_q <= '0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_valid_q  <= alu_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_valid  = alu_valid_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_opcode = rsp_opcode_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = busy_q;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: a registered ALU stand-in, directed plus random stimulus,
// and a transaction-level model whose expected responses sit in a scoreboard queue.
module tb_alu_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned RES_W   = DATA_W + 1;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [2*NUM_REQ-1:0]      req_opcode;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;
  logic [1:0]                alu_opcode;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic                      alu_valid;
  logic [RES_W-1:0]          alu_c;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [1:0]                rsp_opcode;
  logic [RES_W-1:0]          rsp_data;
  logic                      busy;
  logic [15:0]               ops_done;

  alu_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_valid(alu_valid),
    .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_opcode(rsp_opcode), .rsp_data(rsp_data),
    .busy(busy), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU instance stand-in, sharing the scheduler reset
  always @(posedge clk) begin
    if (reset) alu_c <= '0;
    else begin
      case (alu_opcode)
        2'b00:   alu_c <= {alu_a[DATA_W-1], alu_a} + {alu_b[DATA_W-1], alu_b};
        2'b01:   alu_c <= {alu_a[DATA_W-1], alu_a} - {alu_b[DATA_W-1], alu_b};
        2'b10:   alu_c <= ~{alu_a[DATA_W-1], alu_a};
        default: alu_c <= {{DATA_W{1'b0}}, |alu_b};
      endcase
    end
  end

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [RES_W-1:0]  data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          outstanding = 0;
  int          since = 0;
  int          model_rr = 0;
  logic [15:0] model_ops = '0;
  bit          rst_prev = 0;
  bit          do_preload = 0;

  // Result from the op definitions using plain signed integer arithmetic
  function automatic logic [RES_W-1:0] ref_result(input logic [1:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = -sa - 1;
      default: r = (sb != 0) ? 1 : 0;
    endcase
    return RES_W'(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model mid-cycle, then advances the model
  always @(negedge clk) begin : monitor
    logic [NUM_REQ-1:0] exp_ready;
    int   w;
    exp_t e;

    if (rst_prev)
      check("reset_regs", 32'({alu_opcode, alu_a, alu_b, rsp_id, rsp_opcode, rsp_data}), 32'd0);
    check("busy", 32'(busy), 32'(outstanding));
    check("alu_valid", 32'(alu_valid), 32'(outstanding && since == 1));
    check("rsp_valid", 32'(rsp_valid), 32'(outstanding && since >= 3));
    if (outstanding && since == 1 && sb_q.size() > 0)
      check("alu_operands", 32'({alu_opcode, alu_a, alu_b}), 32'({sb_q[0].op, sb_q[0].a, sb_q[0].b}));
    if (rsp_valid) begin
      if (sb_q.size() == 0) check("rsp_unexpected", 32'(1), 32'(0));
      else check("rsp_fields", 32'({rsp_id, rsp_opcode, rsp_data}),
                 32'({sb_q[0].id, sb_q[0].op, sb_q[0].data}));
    end
    if (do_preload) model_ops = 16'hFFFE;
    else check("ops_done", 32'(ops_done), 32'(model_ops));

    exp_ready = '0;
    w = -1;
    if (!reset && !outstanding) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w < 0 && req_valid[(model_rr + k) % NUM_REQ]) w = (model_rr + k) % NUM_REQ;
      end
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    check("req_ready", 32'(req_ready), 32'(exp_ready));

    if (reset) begin
      sb_q.delete();
      outstanding = 0;
      since = 0;
      model_rr = 0;
      model_ops = '0;
    end else if (w >= 0) begin
      e.id   = ID_W'(w);
      e.op   = req_opcode[2*w +: 2];
      e.a    = req_a[DATA_W*w +: DATA_W];
      e.b    = req_b[DATA_W*w +: DATA_W];
      e.data = ref_result(e.op, e.a, e.b);
      sb_q.push_back(e);
      outstanding = 1;
      since = 0;
      model_rr = (w + 1) % NUM_REQ;
    end else if (outstanding && since >= 3 && rsp_ready) begin
      void'(sb_q.pop_front());
      model_ops = model_ops + 16'd1;
      outstanding = 0;
    end
    if (outstanding) since++;
    rst_prev = reset;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [1:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    req_valid[id]               = 1'b1;
    req_opcode[2*id +: 2]       = op;
    req_a[DATA_W*id +: DATA_W]  = a;
    req_b[DATA_W*id +: DATA_W]  = b;
  endtask

  // One-cycle request from an idle scheduler, then enough cycles to drain it
  task automatic issue(input int id, input logic [1:0] op,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    set_req(id, op, a, b);
    step();
    req_valid = '0;
    repeat (5) step();
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    issue(2, 2'b00, 4'd3, 4'd4);
    issue(0, 2'b01, 4'h8, 4'd1);
    issue(1, 2'b00, 4'd7, 4'd7);
    issue(3, 2'b10, 4'd5, 4'd0);
    issue(2, 2'b11, 4'd0, 4'd0);
    issue(1, 2'b11, 4'd0, 4'h8);

    // Fairness from a fresh round-robin pointer
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'(i), 4'(i + 2), 4'(5 - i));
    repeat (24) step();
    req_valid = '0;
    repeat (5) step();

    // Backpressure with competing requests pending
    rsp_ready = 1'b0;
    set_req(0, 2'b01, 4'd2, 4'd6);
    step();
    req_valid = '0;
    for (int i = 1; i < NUM_REQ; i++) set_req(i, 2'b00, 4'(i), 4'(i));
    repeat (12) step();
    rsp_ready = 1'b1;
    repeat (7) step();
    req_valid = '0;
    repeat (5) step();

    // Reset while the accepted op is in EXEC
    set_req(1, 2'b00, 4'd2, 4'd3);
    step();
    req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    issue(3, 2'b01, 4'd6, 4'hA);

    // Counter wrap
    force dut.ops_done_q = 16'hFFFE;
    do_preload = 1'b1;
    step();
    release dut.ops_done_q;
    do_preload = 1'b0;
    issue(0, 2'b00, 4'd1, 4'd1);
    issue(1, 2'b01, 4'd1, 4'd1);

    // Random traffic with random backpressure and occasional reset
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_valid[i]                = ($urandom_range(0, 9) < 4);
        req_opcode[2*i +: 2]        = 2'($urandom);
        req_a[DATA_W*i +: DATA_W]   = 4'($urandom);
        req_b[DATA_W*i +: DATA_W]   = 4'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
